countdown_clk_min: RTL and testbench



---
 rtl/countdown_clk_min_if.sv | 32 +++
 rtl/countdown_clk_min.sv | 107 ++++++++++
 tb/tb_countdown_clk_min.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_clk_min_if.sv
// countdown_clk_min_if
// Groups the control, data and status signals of one countdown time-field
// stage so a whole stage can be wired as a single port.
//   master : drives the ticks, zero chain, start/stop/sub/load controls and
//            preset value; observes count, borrow, zero, run and done.
//   slave  : the countdown stage itself.
interface countdown_clk_min_if #(
    parameter int DW = 6
);
    logic          i_ena;
    logic          i_zero_lo;
    logic          i_start;
    logic          i_stop;
    logic          i_sub;
    logic          i_load;
    logic [DW-1:0] i_load_val;
    logic [DW-1:0] o_count;
    logic          o_brw;
    logic          o_zero;
    logic          o_run;
    logic          o_done;

    modport master (
        output i_ena, i_zero_lo, i_start, i_stop, i_sub, i_load, i_load_val,
        input  o_count, o_brw, o_zero, o_run, o_done
    );

    modport slave (
        input  i_ena, i_zero_lo, i_start, i_stop, i_sub, i_load, i_load_val,
        output o_count, o_brw, o_zero, o_run, o_done
    );
endinterface

// File: rtl/countdown_clk_min.sv
// countdown_clk_min
// One down-counting, cascadable time-field stage (minutes/hours style).
// Holds a value in 0..LIMIT-1, decrements on enable ticks while running,
// wraps from 0 to LIMIT-1, passes a borrow to the next-higher stage and
// reports when it and every lower stage are zero.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : countdown_clk_min_if slave modport
//          i_ena      decrement tick (prescaler or lower-stage borrow)
//          i_zero_lo  all lower stages are zero (tie 1 on lowest stage)
//          i_start    start countdown pulse
//          i_stop     stop/abort countdown pulse
//          i_sub      manual decrement pulse (set-up)
//          i_load     load preset pulse, with i_load_val
//          o_count    current field value
//          o_brw      borrow to next-higher stage (combinational)
//          o_zero     this and all lower stages are zero (combinational)
//          o_run      countdown running
//          o_done     countdown finished (level)
module countdown_clk_min #(
    parameter int LIMIT = 24,
    parameter int DW    = 6
) (
    input  logic                clk,
    input  logic                rst,
    countdown_clk_min_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest legal field value, formed at full integer width before sizing
    // so it is correct even when LIMIT == 2**DW.
    localparam logic [DW-1:0] MAX_VAL = DW'(LIMIT - 1);

    state_t        state;
    logic [DW-1:0] r_count;
    logic [DW-1:0] load_clamped;
    logic [DW-1:0] count_dec;
    logic          count_is_zero;
    logic          chain_zero;

    // Comparing against MAX_VAL rather than LIMIT keeps the compare at DW
    // bits without LIMIT overflowing the field width.
    assign load_clamped  = (bus.i_load_val > MAX_VAL) ? MAX_VAL : bus.i_load_val;
    assign count_is_zero = (r_count == '0);
    assign count_dec     = count_is_zero ? MAX_VAL : (r_count - DW'(1));
    assign chain_zero    = count_is_zero & bus.i_zero_lo;

    assign bus.o_count = r_count;
    assign bus.o_zero  = chain_zero;
    // Borrow only while running and only when lower stages still hold time,
    // so the higher stage decrements exactly when this one wraps.
    assign bus.o_brw   = (state == RUN) & bus.i_ena & count_is_zero & ~bus.i_zero_lo;
    assign bus.o_run   = (state == RUN);
    assign bus.o_done  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            r_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_load) begin
                        r_count <= load_clamped;
                    end else if (bus.i_start) begin
                        // Starting an already-expired chain would finish
                        // instantly, so it is simply ignored.
                        if (!chain_zero) begin
                            state <= RUN;
                        end
                    end else if (bus.i_sub) begin
                        r_count <= count_dec;
                    end
                end
                RUN: begin
                    if (bus.i_stop) begin
                        state <= IDLE;
                    end else if (chain_zero) begin
                        // A tick arriving together with the zero detect is
                        // dropped, otherwise the chain would wrap past zero.
                        state <= DONE;
                    end else if (bus.i_ena) begin
                        r_count <= count_dec;
                    end
                end
                DONE: begin
                    if (bus.i_load) begin
                        r_count <= load_clamped;
                        state   <= IDLE;
                    end else if (bus.i_stop) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_clk_min.sv
// tb_countdown_clk_min
// Directed bench for countdown_clk_min with LIMIT=24, DW=6. Inputs change
// 1 time unit after each rising edge; outputs are sampled there as well, so
// every check is well away from the active edge.
module tb_countdown_clk_min;

    localparam int LIMIT = 24;
    localparam int DW    = 6;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic lastBrw;
    logic anyBrw;

    countdown_clk_min_if #(.DW(DW)) bus ();

    countdown_clk_min #(
        .LIMIT (LIMIT),
        .DW    (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of controls, captures the combinational borrow just
    // before the edge, then lets one rising edge pass and clears the pulses.
    task automatic applyStimulus(input logic ld, input int val, input logic st,
                                 input logic sp, input logic sb, input logic en);
        bus.i_load     = ld;
        bus.i_load_val = DW'(val);
        bus.i_start    = st;
        bus.i_stop     = sp;
        bus.i_sub      = sb;
        bus.i_ena      = en;
        #1;
        lastBrw = bus.o_brw;
        @(posedge clk);
        #1;
        bus.i_load  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_ena   = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        lastBrw        = 1'b0;
        anyBrw         = 1'b0;
        rst            = 1'b1;
        bus.i_ena      = 1'b0;
        bus.i_zero_lo  = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_stop     = 1'b0;
        bus.i_sub      = 1'b0;
        bus.i_load     = 1'b0;
        bus.i_load_val = '0;

        // Reset state
        #12;
        checkOutput("rst_count", int'(bus.o_count), 0);
        checkOutput("rst_run",   int'(bus.o_run),   0);
        checkOutput("rst_done",  int'(bus.o_done),  0);
        checkOutput("rst_brw",   int'(bus.o_brw),   0);
        checkOutput("rst_zero1", int'(bus.o_zero),  1);
        bus.i_zero_lo = 1'b0;
        #1;
        checkOutput("rst_zero0", int'(bus.o_zero),  0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.i_zero_lo = 1'b1;

        // Load 5, start, count down to zero with lower stages at zero
        applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load5", int'(bus.o_count), 5);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_run", int'(bus.o_run), 1);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            anyBrw = anyBrw | lastBrw;
            checkOutput($sformatf("down_%0d", i), int'(bus.o_count), i);
        end
        checkOutput("down_nobrw", int'(anyBrw), 0);
        checkOutput("at0_zero", int'(bus.o_zero), 1);
        checkOutput("at0_done", int'(bus.o_done), 0);
        checkOutput("at0_run",  int'(bus.o_run),  1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("enter_done",   int'(bus.o_done),  1);
        checkOutput("enter_run0",   int'(bus.o_run),   0);
        checkOutput("done_nobrw",   int'(lastBrw),     0);
        checkOutput("done_hold",    int'(bus.o_count), 0);

        // In DONE: start and tick are ignored, load returns to IDLE
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("done_ign_done",  int'(bus.o_done),  1);
        checkOutput("done_ign_count", int'(bus.o_count), 0);
        applyStimulus(1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_load_count", int'(bus.o_count), 12);
        checkOutput("done_load_done",  int'(bus.o_done),  0);
        checkOutput("done_load_run",   int'(bus.o_run),   0);

        // Wrap with borrow: load 0, lower stages non-zero, one tick
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.i_zero_lo = 1'b0;
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_run", int'(bus.o_run), 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_brw",   int'(lastBrw),     1);
        checkOutput("wrap_count", int'(bus.o_count), 23);
        checkOutput("wrap_run2",  int'(bus.o_run),   1);
        checkOutput("wrap_brw_low", int'(bus.o_brw), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_stop", int'(bus.o_run), 0);

        // Manual decrement in IDLE, ticks ignored
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sub_wrap", int'(bus.o_count), 23);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sub_21", int'(bus.o_count), 21);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("idle_ena_ign", int'(bus.o_count), 21);
        checkOutput("idle_ena_brw", int'(lastBrw),     0);

        // Load clamp and priorities in IDLE
        applyStimulus(1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clamp40", int'(bus.o_count), 23);
        applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 24, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_st_count", int'(bus.o_count), 23);
        checkOutput("ld_st_run",   int'(bus.o_run),   0);
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.i_zero_lo = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_at_zero", int'(bus.o_run), 0);

        // RUN at 9: stop beats tick, then asynchronous reset mid-run
        applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("run9", int'(bus.o_run), 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stop_ena_run",   int'(bus.o_run),   0);
        checkOutput("stop_ena_count", int'(bus.o_count), 9);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("run_at7", int'(bus.o_count), 7);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_count", int'(bus.o_count), 0);
        checkOutput("async_rst_run",   int'(bus.o_run),   0);
        checkOutput("async_rst_brw",   int'(bus.o_brw),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_count", int'(bus.o_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
